// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared types for the two-master SDRAM Wishbone arbiter.
//   arb_state_e     : FSM state, encoding matches the debug_state port (0/1/2)
//   owner_t         : which master currently owns the slave port
//   TIMEOUT_DEFAULT : default watchdog limit in cycles (0 disables it)
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/sdram_arb_wdt.sv
// sdram_arb_wdt
// Watchdog counter for the arbiter. Counts cycles while enabled, clears on
// request, and flags expiry in the cycle the count reaches TIMEOUT_CYCLES-1.
// With TIMEOUT_CYCLES=0 no counter is built and expire is tied low.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reset the count to zero (wins over enable)
//   enable     : count this cycle
//   expire     : limit reached while enabled (combinational)
module sdram_arb_wdt
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdt
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Next count: clear has priority so a fresh grant always starts at zero.
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire = enable && (cnt_q == LIMIT);
    end else begin : g_no_wdt
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter
// Two-master Wishbone Classic arbiter in front of the SDRAM controller.
// Master 0 is the video line fetcher, master 1 the CPU bridge. One transfer
// is granted at a time; ack/err are routed only to the owner, an abandoned
// transfer is drained until the slave acks, and a stuck slave is timed out.
// Ports:
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   m0_* / m1_*                : master-side Wishbone ports (cyc/stb/we/adr/dat/sel in,
//                                ack/err out)
//   m_dat_o                    : read data broadcast to both masters (= s_dat_i)
//   s_*                        : slave-side Wishbone port to the SDRAM controller
//   debug_state                : current FSM state (0 idle, 1 busy, 2 drain)
// Build option:
//   SDRAM_ARB_ROUND_ROBIN_EN   : when defined, simultaneous requests go to the
//                                master that was not served last; otherwise
//                                master 0 always wins.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH  = 24,
  parameter int unsigned WB_DATA_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       m0_cyc_i,
  input  logic                       m0_stb_i,
  input  logic                       m0_we_i,
  input  logic [WB_ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                       m0_ack_o,
  output logic                       m0_err_o,
  input  logic                       m1_cyc_i,
  input  logic                       m1_stb_i,
  input  logic                       m1_we_i,
  input  logic [WB_ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                       m1_ack_o,
  output logic                       m1_err_o,
  output logic [WB_DATA_WIDTH-1:0]   m_dat_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [WB_ADDR_WIDTH-1:0]   s_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_o,
  output logic [WB_DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                       s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_i,
  output logic [1:0]                 debug_state
);

  arb_state_e state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     last_served_q, last_served_d;

  logic req0, req1, winner;
  logic wdt_clear, wdt_expire;

  logic                       own_cyc, own_stb, own_we;
  logic [WB_ADDR_WIDTH-1:0]   own_adr;
  logic [WB_DATA_WIDTH-1:0]   own_dat;
  logic [WB_DATA_WIDTH/8-1:0] own_sel;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // On a tie, hand the slot to whoever was not served last.
  assign winner = (req0 && req1) ? ~last_served_q : (req0 ? OWNER_M0 : OWNER_M1);
`else
  assign winner = req0 ? OWNER_M0 : OWNER_M1;
`endif

  assign own_cyc = (owner_q == OWNER_M1) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (owner_q == OWNER_M1) ? m1_stb_i : m0_stb_i;
  assign own_we  = (owner_q == OWNER_M1) ? m1_we_i  : m0_we_i;
  assign own_adr = (owner_q == OWNER_M1) ? m1_adr_i : m0_adr_i;
  assign own_dat = (owner_q == OWNER_M1) ? m1_dat_i : m0_dat_i;
  assign own_sel = (owner_q == OWNER_M1) ? m1_sel_i : m0_sel_i;

  assign m_dat_o     = s_dat_i;
  assign debug_state = state_q;

  sdram_arb_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clear  (wdt_clear),
    .enable (state_q != ST_IDLE),
    .expire (wdt_expire)
  );

  // Next-state and output decode. Slave outputs are only driven in BUSY, so
  // an owner dropping cyc removes the strobe in the same cycle. An ack seen
  // in IDLE or DRAIN is swallowed so it can never be credited to a new owner.
  // Ack beats timeout when both land in the same cycle.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    wdt_clear     = 1'b0;
    m0_ack_o      = 1'b0;
    m1_ack_o      = 1'b0;
    m0_err_o      = 1'b0;
    m1_err_o      = 1'b0;
    s_cyc_o       = 1'b0;
    s_stb_o       = 1'b0;
    s_we_o        = 1'b0;
    s_adr_o       = '0;
    s_dat_o       = '0;
    s_sel_o       = '0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d   = winner;
          state_d   = ST_BUSY;
          wdt_clear = 1'b1;
        end
      end

      ST_BUSY: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_cyc & own_stb;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        s_sel_o = own_sel;
        if (s_ack_i) begin
          m0_ack_o      = (owner_q == OWNER_M0);
          m1_ack_o      = (owner_q == OWNER_M1);
          state_d       = ST_IDLE;
          last_served_d = owner_q;
        end else if (!own_cyc) begin
          state_d = ST_DRAIN;
        end else if (wdt_expire) begin
          m0_err_o = (owner_q == OWNER_M0);
          m1_err_o = (owner_q == OWNER_M1);
          state_d  = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (s_ack_i || wdt_expire) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWNER_M0;
      last_served_q <= OWNER_M1;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
    end
  end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
Two-master Wishbone Classic arbiter sitting directly upstream of the SDRAM Wishbone controller (single slave port). Master 0 is the video line fetcher; master 1 is the CPU bus bridge. Grants one transfer at a time, routes ack/data back to the owner, drains orphaned transfers and times out a stuck slave.

Parameters:
WB_ADDR_WIDTH, 24, address width on all ports
WB_DATA_WIDTH, 16, data width on all ports
TIMEOUT_CYCLES, 64, max cycles granted without slave ack; 0 disables the watchdog

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (video) control
m0_adr_i  in  WB_ADDR_WIDTH  master 0 address
m0_dat_i  in  WB_DATA_WIDTH  master 0 write data
m0_sel_i  in  WB_DATA_WIDTH/8  master 0 byte select
m0_ack_o, m0_err_o  out  1 each  master 0 ack / timeout error
m1_*  same set as m0_*  master 1 (CPU)
m_dat_o  out  WB_DATA_WIDTH  read data, broadcast to both masters
s_cyc_o, s_stb_o, s_we_o  out  1 each  to SDRAM controller
s_adr_o  out  WB_ADDR_WIDTH;  s_dat_o  out  WB_DATA_WIDTH;  s_sel_o  out  WB_DATA_WIDTH/8
s_ack_i  in  1;  s_dat_i  in  WB_DATA_WIDTH  from controller
debug_state  out  2  {state}

Behaviour:
- Reset (async, wb_rst_ni=0): state=IDLE, owner=0, last_served=1, wdt=0. All s_* outputs 0, m*_ack_o=0, m*_err_o=0, m_dat_o follows s_dat_i (combinational pass-through).
- States: IDLE, BUSY, DRAIN.
- IDLE: s_cyc_o=s_stb_o=0. Requester mN = mN_cyc_i & mN_stb_i. If any requester: owner<=winner, state<=BUSY, wdt<=0. Fixed priority: m0 beats m1. s_ack_i in IDLE is discarded, never routed.
- BUSY: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o = owner's inputs (combinational mux, gated by state==BUSY). mOwner_ack_o = s_ack_i (same cycle); the other master's ack is 0. On s_ack_i: state<=IDLE, last_served<=owner. Latency: request seen in cycle N, slave strobe in N+1, so there is always at least one idle cycle between consecutive grants (controller samples requests only in its own idle state).
- Abort: owner drops cyc in BUSY without ack -> state<=DRAIN; s_cyc_o/s_stb_o deasserted immediately.
- DRAIN: slave outputs 0; wait for s_ack_i (swallowed, not routed) then IDLE. This prevents a late ack being credited to the next owner.
- Watchdog (TIMEOUT_CYCLES>0): wdt increments each BUSY/DRAIN cycle and clears on entry to BUSY. When wdt==TIMEOUT_CYCLES-1 with no ack: in BUSY, mOwner_err_o pulses 1 cycle and state<=IDLE; in DRAIN, state<=IDLE silently. An ack and timeout in the same cycle count as an ack (no err).
- Simultaneous m0/m1 requests in IDLE: arbitration rule above; the loser's request is held by the master (Wishbone classic) and granted at the next IDLE.
- err and ack are never asserted together; at most one master ack/err per cycle.
- Reset mid-BUSY: outputs drop asynchronously; the SDRAM controller is reset on the same domain.

Optional Feature:
SDRAM_ARB_ROUND_ROBIN_EN — when defined, simultaneous requests in IDLE go to the master != last_served; a lone requester is always granted. When undefined, fixed priority (m0 always wins); last_served is still tracked but unused.

Decomposition:
- Package sdram_arb_pkg: state enum {IDLE, BUSY, DRAIN} (2 bits, matches debug_state encoding 0/1/2), owner type, TIMEOUT default constant.
- One sub-module: sdram_arb_wdt (clear/enable/expire counter, width $clog2(TIMEOUT_CYCLES+1), generates nothing when TIMEOUT_CYCLES=0).

Test Plan:
- m1 read 0x000123, slave acks after 6 cycles with 0xBEEF -> s_stb_o rises 1 cycle after request, m1_ack_o 1 cycle with m_dat_o=0xBEEF, m0_ack_o stays 0.
- m0 and m1 request in the same cycle (m0 write 0x00A000/0x1234, m1 read 0x000010) -> m0 is granted first, m1 after m0's ack plus one IDLE cycle; with SDRAM_ARB_ROUND_ROBIN_EN and last_served=0, m1 is granted first.
- m1 drops cyc 2 cycles into BUSY, slave acks 4 cycles later -> DRAIN, ack not routed; a pending m0 request is granted only after that ack.
- TIMEOUT_CYCLES=8, slave never acks -> m0_err_o pulses on the 8th BUSY cycle, state returns to IDLE, s_stb_o=0.
- wb_rst_ni pulsed low mid-BUSY -> all s_* and m*_ack/err go 0 immediately; debug_state=0.
- Back-to-back m1 writes where m1 holds cyc/stb high -> each ack is followed by exactly one cycle of s_stb_o=0 before the next grant.
